// File: rtl/motor_enc_pkg.sv
// Shared definitions for the motor encoder emulator: phase encoding and quadrature sequencing.
package motor_enc_pkg;

  localparam int unsigned ACC_W = 24;
  localparam int unsigned POS_W = 32;
  localparam int unsigned STEP_MAX = 1 << ACC_W;

  // State value is {sa, sb}, so the outputs decode directly from the register
  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P10 = 2'b10,
    P11 = 2'b11
  } phase_t;

  // Indexed by current phase value: forward 00->10->11->01->00, reverse the opposite way
  localparam phase_t FWD_NEXT [4] = '{P10, P00, P11, P01};
  localparam phase_t REV_NEXT [4] = '{P01, P11, P00, P10};

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/motor_enc_emu.sv
// Quadrature encoder emulator: integrates PWM-high time and emits A/B edges plus a signed position.
module motor_enc_emu
  import motor_enc_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 200_000_000,
  parameter int unsigned STEP_CYC = 2000
) (
  input  logic                    clk200M,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    pwm,
  input  logic                    dir,
  output logic                    sa,
  output logic                    sb,
  output logic signed [POS_W-1:0] pos,
  output logic                    step
);

  if (STEP_CYC < 2 || STEP_CYC > STEP_MAX || CLK_FREQ == 0) begin : g_bad_param
    $error("motor_enc_emu: STEP_CYC=%0d outside 2..%0d", STEP_CYC, STEP_MAX);
  end

  logic             pwm_s;
  logic             dir_s;
  logic             dir_q;
  logic [ACC_W-1:0] acc;
  phase_t           phase;
  phase_t           next_phase;

  sync_2ff u_sync_pwm (.clk(clk200M), .rst_n(rstn), .d(pwm), .q(pwm_s));
  sync_2ff u_sync_dir (.clk(clk200M), .rst_n(rstn), .d(dir), .q(dir_s));

  assign next_phase = dir_s ? FWD_NEXT[phase] : REV_NEXT[phase];
  assign sa         = phase[1];
  assign sb         = phase[0];

  // Direction change and disable both restart integration; a change wins over terminal count
  always_ff @(posedge clk200M or negedge rstn) begin
    if (!rstn) begin
      dir_q <= 1'b0;
      acc   <= '0;
      phase <= P00;
      pos   <= '0;
      step  <= 1'b0;
    end else begin
      dir_q <= dir_s;
      step  <= 1'b0;
      if (!en || (dir_s != dir_q)) begin
        acc <= '0;
      end else if (pwm_s) begin
        if (acc == ACC_W'(STEP_CYC - 1)) begin
          acc   <= '0;
          phase <= next_phase;
          pos   <= dir_s ? pos + 32'sd1 : pos - 32'sd1;
          step  <= 1'b1;
        end else begin
          acc <= acc + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/motor_enc_emu.md
MOTOR_ENC_EMU -- requirements
Module: motor_enc_emu

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 200_000_000, system clock frequency in Hz (informational; used for the STEP_CYC legality check).
REQ-002 SHALL have parameter STEP_CYC, default 2000, number of pwm-high clock cycles per quadrature edge; legal range 2..2^24.
REQ-003 SHALL have port clk200M, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, emulator enable, synchronous to clk200M.
REQ-006 SHALL have port pwm, input, 1, motor drive PWM, asynchronous (pin loopback).
REQ-007 SHALL have port dir, input, 1, motor direction, asynchronous; 1 = forward.
REQ-008 SHALL have port sa, output, 1, encoder phase A, registered.
REQ-009 SHALL have port sb, output, 1, encoder phase B, registered.
REQ-010 SHALL have port pos, output, 32, signed emulated shaft position in quadrature edges, registered.
REQ-011 SHALL have port step, output, 1, single-cycle pulse coincident with each sa/sb change.

Function
REQ-012 SHALL pass pwm and dir through 2-FF synchronizers (pwm_s, dir_s) before any use; input-to-accumulator latency is 2 cycles.
REQ-013 SHALL keep a 24-bit accumulator acc counting cycles with en=1 and pwm_s=1; acc holds when pwm_s=0.
REQ-014 SHALL, when en=1, pwm_s=1 and acc==STEP_CYC-1, clear acc and advance the quadrature phase by one edge, with sa, sb, pos and step updating on that same clock edge.
REQ-015 SHALL use forward (dir_s=1) sequence (sa,sb) 00->10->11->01->00 (A leads B); reverse sequence 00->01->11->10->00.
REQ-016 SHALL increment pos by 1 per forward step and decrement it by 1 per reverse step, wrapping modulo 2^32 with no saturation.
REQ-017 SHALL clear acc, without stepping, on any cycle where dir_s differs from its previous-cycle value; this takes priority over a simultaneous terminal count.
REQ-018 SHALL force acc to 0 and hold sa, sb and pos while en=0; step SHALL be 0 while en=0.
REQ-019 SHALL assert step for exactly one cycle per phase advance and never on consecutive cycles (guaranteed by STEP_CYC>=2).
REQ-020 SHALL change exactly one of sa and sb per step (Gray-coded; no double transitions).
REQ-021 SHALL be a 4-state phase FSM, P00/P10/P11/P01, with transitions only as listed in REQ-015; sa and sb are decoded from the state register.

Reset
REQ-022 SHALL, on rstn=0 at any time including mid-step, immediately clear sync flops, acc, phase (P00), sa=0, sb=0, pos=0 and step=0.
REQ-023 SHALL resume counting from acc=0 after rstn deasserts, honouring the 2-cycle synchronizer latency.

Structure
REQ-024 SHALL take the phase-state typedef (P00..P01) and the forward/reverse next-state constants from shared package motor_enc_pkg.
REQ-025 SHALL instantiate sub-module sync_2ff (1-bit, async active-low reset) twice, for pwm and dir.
REQ-026 SHALL reject STEP_CYC outside the legal range via an elaboration-time assertion.

Verification
REQ-027 SHALL verify reset: rstn=0 -> sa=0, sb=0, pos=0, step=0 asynchronously, without waiting for a clock edge.
REQ-028 SHALL verify forward motion: STEP_CYC=4, en=1, dir=1, pwm held 1 -> first step 6 cycles after pwm rises, then every 4 cycles; (sa,sb)=10,11,01,00; pos=4 after 4 steps.
REQ-029 SHALL verify reverse motion: same as REQ-028 with dir=0 -> (sa,sb)=01,11,10,00; pos=0xFFFF_FFFC after 4 steps.
REQ-030 SHALL verify duty scaling: STEP_CYC=4, pwm 2 cycles high / 2 cycles low -> steady-state step spacing 8 cycles.
REQ-031 SHALL verify direction-change priority: dir_s toggles on the cycle acc==3 with pwm_s=1 -> no step, acc=0, next step 4 pwm-high cycles later in the new direction.
REQ-032 SHALL verify enable and mid-operation reset: en=0 for 10 cycles -> sa, sb, pos frozen with step=0; rstn pulsed at acc=2 -> all outputs 0, first step 6 cycles after release.
